// File: rtl/data_mem_arbiter_pkg.sv
// data_mem_arbiter_pkg: shared state encodings, port IDs and the latched request record.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package data_mem_arbiter_pkg;

   // Sequencer states: one issue cycle, a busy wait, then a one-cycle completion.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Requester IDs, also used as the round-robin pointer value.
   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_DBG  = 1'b1;

   // One data_mem access as presented by a requester.
   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  mask;
   } req_t;

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; on a tie the port that did not win last time wins.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is taken.
module rr_arbiter2 (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic gnt,
   output logic gnt_id
);

   // Pick the single requester, or alternate away from the previous winner on a tie.
   always_comb begin
      gnt    = req0 | req1;
      gnt_id = 1'b0;
      if (req0 && req1) begin
         gnt_id = ~last;
      end else if (req1) begin
         gnt_id = 1'b1;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin share of the single data_mem port between core (0) and dbg (1).
// Latency: valid sampled in IDLE at edge N -> done high in cycle N+4 for a one-cycle busy; one access per 5 cycles.
// Backpressure: requester holds valid until its done pulse and is frozen by *_stall; DATA_MEM_ARB_TIMEOUT_EN aborts a stuck WAIT.
module data_mem_arbiter
   import data_mem_arbiter_pkg::*;
#(
`ifdef DATA_MEM_ARB_TIMEOUT_EN
   parameter int   TIMEOUT_CYCLES = 64,
`endif
   parameter logic RESET_PRIO     = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        core_valid,
   input  logic        core_write,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wdata,
   input  logic [2:0]  core_mask,
   output logic [31:0] core_rdata,
   output logic        core_done,
   output logic        core_err,
   output logic        core_stall,
   input  logic        dbg_valid,
   input  logic        dbg_write,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   input  logic [2:0]  dbg_mask,
   output logic [31:0] dbg_rdata,
   output logic        dbg_done,
   output logic        dbg_err,
   output logic        dbg_stall,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [2:0]  mem_mask,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_rdata,
   input  logic        mem_busy
);

   req_t        core_req;
   req_t        dbg_req;
   req_t        sel_req;
   req_t        req_q;
   logic [1:0]  state;
   logic        owner;
   logic        last_gnt;
   logic        gnt;
   logic        gnt_id;
   logic [1:0]  done_q;
   logic [31:0] rdata_q [2];

   assign core_req = '{write: core_write, addr: core_addr, wdata: core_wdata, mask: core_mask};
   assign dbg_req  = '{write: dbg_write,  addr: dbg_addr,  wdata: dbg_wdata,  mask: dbg_mask};
   assign sel_req  = (gnt_id == PORT_DBG) ? dbg_req : core_req;

   rr_arbiter2 u_arb (
      .req0   (core_valid),
      .req1   (dbg_valid),
      .last   (last_gnt),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   // The latched request drives data_mem for the whole access.
   assign mem_addr   = req_q.addr;
   assign mem_wdata  = req_q.wdata;
   assign mem_mask   = req_q.mask;

   assign core_rdata = rdata_q[PORT_CORE];
   assign dbg_rdata  = rdata_q[PORT_DBG];
   assign core_done  = done_q[PORT_CORE];
   assign dbg_done   = done_q[PORT_DBG];
   assign core_stall = core_valid & ~core_done;
   assign dbg_stall  = dbg_valid & ~dbg_done;

`ifdef DATA_MEM_ARB_TIMEOUT_EN
   logic [15:0] wait_cnt;
   logic [1:0]  err_q;

   assign core_err = err_q[PORT_CORE];
   assign dbg_err  = err_q[PORT_DBG];
`else
   assign core_err = 1'b0;
   assign dbg_err  = 1'b0;
`endif

   // Access sequencer: grant and latch in IDLE, strobe in ISSUE, wait out busy, pulse done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         owner      <= PORT_CORE;
         last_gnt   <= ~RESET_PRIO;
         req_q      <= '0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         done_q     <= '0;
         rdata_q[0] <= '0;
         rdata_q[1] <= '0;
`ifdef DATA_MEM_ARB_TIMEOUT_EN
         err_q      <= '0;
         wait_cnt   <= '0;
`endif
      end else begin
         // Strobes and completion flags are single-cycle unless re-asserted below.
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         done_q    <= '0;
`ifdef DATA_MEM_ARB_TIMEOUT_EN
         err_q     <= '0;
`endif
         case (state)
            ST_IDLE: begin
               if (gnt) begin
                  owner     <= gnt_id;
                  last_gnt  <= gnt_id;
                  req_q     <= sel_req;
                  mem_read  <= ~sel_req.write;
                  mem_write <= sel_req.write;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               state <= ST_WAIT;
`ifdef DATA_MEM_ARB_TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end
            ST_WAIT: begin
               // data_mem raises busy the cycle after issue, so the first WAIT cycle never exits.
               if (!mem_busy) begin
                  if (!req_q.write) begin
                     rdata_q[owner] <= mem_rdata;
                  end
                  done_q[owner] <= 1'b1;
                  state         <= ST_DONE;
               end
`ifdef DATA_MEM_ARB_TIMEOUT_EN
               else if (wait_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                  done_q[owner] <= 1'b1;
                  err_q[owner]  <= 1'b1;
                  state         <= ST_DONE;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
`endif
            end
            ST_DONE: begin
               // Valids are ignored here so the finished requester can drop its valid first.
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
